// File: rtl/alu_pkg.sv
// Types and widths shared by the ALU operand front-end and its consumers.
package alu_pkg;

    localparam int OPERAND_W = 8;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        READY  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, tick-based debounce and registered rising-edge strobe for a raw button.
// Latency: 2 sync cycles + DEBOUNCE_TICKS ticks + 1 cycle to rise_pulse; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic rise_pulse
);

    localparam int CNT_W = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             btn_s_q, btn_s_d;
    logic             btn_db_q, btn_db_d;
    logic             db_prev_q, db_prev_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_raw;
        btn_s_d  = sync1_q;
        btn_db_d = btn_db_q;
        cnt_d    = cnt_q;
        // Any agreement restarts the stability window; disagreement advances only on ticks.
        if (btn_s_q == btn_db_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_MAX) begin
                btn_db_d = btn_s_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        db_prev_d = btn_db_q;
        rise_d    = btn_db_q & ~db_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            btn_s_q   <= 1'b0;
            btn_db_q  <= 1'b0;
            db_prev_q <= 1'b0;
            rise_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            btn_s_q   <= btn_s_d;
            btn_db_q  <= btn_db_d;
            db_prev_q <= db_prev_d;
            rise_q    <= rise_d;
            cnt_q     <= cnt_d;
        end
    end

    assign btn_level  = btn_db_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/operand_loader.sv
// Captures two successive bus words into ALU operands A and B on debounced button presses.
// Latency: press to register update is 2 + DEBOUNCE_TICKS ticks + 2 cycles; no backpressure.
module operand_loader
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 btn_load,
    input  logic                 clear,
    input  logic [OPERAND_W-1:0] data_in,
    output logic [OPERAND_W-1:0] reg_a,
    output logic [OPERAND_W-1:0] reg_b,
    output logic                 operands_valid,
    output logic                 load_pulse,
    output logic [1:0]           state
);

    logic                 btn_level;
    logic                 rise_pulse;
    loader_state_t        state_q, state_d;
    logic [OPERAND_W-1:0] reg_a_q, reg_a_d;
    logic [OPERAND_W-1:0] reg_b_q, reg_b_d;
    logic                 valid_q, valid_d;

    btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_btn_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .btn_raw    (btn_load),
        .btn_level  (btn_level),
        .rise_pulse (rise_pulse)
    );

    // The debounced level cannot drop within one cycle of rising, so this only guards against misuse.
    assign load_pulse = rise_pulse & btn_level;

    always_comb begin
        state_d = state_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        valid_d = valid_q;
        if (clear) begin
            state_d = WAIT_A;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (load_pulse) begin
                        reg_a_d = data_in;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_pulse) begin
                        reg_b_d = data_in;
                        valid_d = 1'b1;
                        state_d = READY;
                    end
                end
                READY: begin
                    // A new A invalidates the pair; the stale B is kept until overwritten.
                    if (load_pulse) begin
                        reg_a_d = data_in;
                        valid_d = 1'b0;
                        state_d = WAIT_B;
                    end
                end
                default: begin
                    state_d = WAIT_A;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            reg_a_q <= '0;
            reg_b_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            valid_q <= valid_d;
        end
    end

    assign reg_a          = reg_a_q;
    assign reg_b          = reg_b_q;
    assign operands_valid = valid_q;
    assign state          = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: vector table, directed corner cases, random run against a model.
module tb_operand_loader;
    import alu_pkg::*;

    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       btn_load = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] reg_a, reg_b;
    logic       operands_valid, load_pulse;
    logic [1:0] state;

    operand_loader #(.DEBOUNCE_TICKS(DT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .btn_load       (btn_load),
        .clear          (clear),
        .data_in        (data_in),
        .reg_a          (reg_a),
        .reg_b          (reg_b),
        .operands_valid (operands_valid),
        .load_pulse     (load_pulse),
        .state          (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int tick_period = 1;
    int pulse_cnt = 0;

    // Reference model: button history, disagreement streak in ticks, and a count of loads since clear.
    bit         m_s1, m_s2, m_db, m_rose, m_pulse;
    int         m_streak;
    int         m_n;
    logic [7:0] m_a, m_b;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_rose = 0; m_pulse = 0;
        m_streak = 0; m_n = 0; m_a = 8'h00; m_b = 8'h00;
    endtask

    task automatic model_edge();
        // Loads alternate A, B, A, B... after each clear; clear wins over a pending load.
        if (clear) begin
            m_n = 0;
        end else if (m_pulse) begin
            if (m_n % 2 == 0) m_a = data_in;
            else              m_b = data_in;
            m_n++;
            if (m_n >= 4) m_n -= 2;
        end
        m_pulse = m_rose;
        m_rose  = 0;
        if (m_s2 == m_db) begin
            m_streak = 0;
        end else if (tick) begin
            m_streak++;
            if (m_streak == DT) begin
                m_db     = m_s2;
                m_streak = 0;
                m_rose   = m_db;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_load;
    endtask

    function automatic logic [1:0] m_state();
        if (m_n == 0) return 2'd0;
        return (m_n % 2 == 1) ? 2'd1 : 2'd2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        check("reg_a", reg_a, m_a);
        check("reg_b", reg_b, m_b);
        check("operands_valid", operands_valid, (m_n > 0 && m_n % 2 == 0) ? 1 : 0);
        check("load_pulse", load_pulse, m_pulse);
        check("state", state, m_state());
    endtask

    task automatic set_tick();
        tick = (tick_period > 0) && (cyc % tick_period == 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        if (load_pulse) pulse_cnt++;
        compare_all();
        cyc++;
        set_tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn_load = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        cyc = 0; pulse_cnt = 0;
        set_tick();
    endtask

    task automatic press(input logic [7:0] d);
        btn_load = 1'b1; data_in = d;
        repeat (10) step();
        btn_load = 1'b0;
        repeat (12) step();
    endtask

    typedef struct {
        int         hold;
        int         period;
        logic [7:0] data;
        int         exp_pulses;
        logic [1:0] exp_state;
        logic [7:0] exp_a;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{3,   1, 8'h5A, 0, 2'd0, 8'h00};
        vecs[1] = '{4,   1, 8'hC3, 1, 2'd1, 8'hC3};
        vecs[2] = '{10,  1, 8'h5A, 1, 2'd1, 8'h5A};
        vecs[3] = '{200, 4, 8'h3C, 1, 2'd1, 8'h3C};
        vecs[4] = '{50,  0, 8'h77, 0, 2'd0, 8'h00};
        vecs[5] = '{6,   2, 8'hE1, 0, 2'd0, 8'h00};
        vecs[6] = '{8,   2, 8'hE1, 1, 2'd1, 8'hE1};

        #1 rst_n = 1'b0;
        #1;
        check("rst reg_a", reg_a, 0);
        check("rst reg_b", reg_b, 0);
        check("rst valid", operands_valid, 0);
        check("rst load_pulse", load_pulse, 0);
        check("rst state", state, 0);
        @(negedge clk);

        // Press-length / tick-rate table from reset.
        for (int v = 0; v < 7; v++) begin
            tick_period = 1;
            do_reset();
            tick_period = vecs[v].period;
            set_tick();
            btn_load = 1'b1; data_in = vecs[v].data;
            repeat (vecs[v].hold) step();
            btn_load = 1'b0;
            repeat (30) step();
            check($sformatf("vec%0d pulses", v), pulse_cnt, vecs[v].exp_pulses);
            check($sformatf("vec%0d state", v), state, vecs[v].exp_state);
            check($sformatf("vec%0d reg_a", v), reg_a, vecs[v].exp_a);
        end

        // Basic sequence with exact edge timing.
        tick_period = 1;
        do_reset();
        btn_load = 1'b1; data_in = 8'h5A;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 6) check("basic pulse e6", load_pulse, 0);
            if (e == 7) begin
                check("basic pulse e7", load_pulse, 1);
                check("basic reg_a e7", reg_a, 8'h00);
            end
            if (e == 8) begin
                check("basic reg_a e8", reg_a, 8'h5A);
                check("basic state e8", state, 2'd1);
                check("basic pulse e8", load_pulse, 0);
            end
        end
        btn_load = 1'b0;
        repeat (12) step();
        press(8'hA5);
        check("basic reg_a", reg_a, 8'h5A);
        check("basic reg_b", reg_b, 8'hA5);
        check("basic valid", operands_valid, 1);
        check("basic state", state, 2'd2);
        check("basic pulses", pulse_cnt, 2);

        // Reload from READY keeps B and drops valid.
        do_reset();
        press(8'h11);
        press(8'h22);
        press(8'h77);
        check("reload reg_a", reg_a, 8'h77);
        check("reload reg_b", reg_b, 8'h22);
        check("reload valid", operands_valid, 0);
        check("reload state", state, 2'd1);

        // Clear coinciding with the load strobe in WAIT_B.
        do_reset();
        press(8'h11);
        begin
            int found = 0;
            btn_load = 1'b1; data_in = 8'h99;
            for (int i = 0; i < 20 && found == 0; i++) begin
                step();
                if (load_pulse) found = 1;
            end
            check("clear pulse seen", found, 1);
            if (found == 1) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
                check("clear state", state, 2'd0);
                check("clear valid", operands_valid, 0);
                check("clear reg_b", reg_b, 8'h00);
                check("clear reg_a", reg_a, 8'h11);
            end
            btn_load = 1'b0;
            repeat (12) step();
        end

        // Slow tick, long hold: one load, capturing the bus value at the strobe edge.
        begin
            logic [7:0] exp_d = 8'h00;
            do_reset();
            tick_period = 4;
            set_tick();
            btn_load = 1'b1;
            data_in = 8'($urandom);
            for (int i = 0; i < 200; i++) begin
                step();
                data_in = 8'($urandom);
                if (load_pulse) exp_d = data_in;
            end
            btn_load = 1'b0;
            repeat (30) step();
            check("slow pulses", pulse_cnt, 1);
            check("slow reg_a", reg_a, exp_d);
            check("slow state", state, 2'd1);
        end

        // Asynchronous reset mid-sequence with a debounce in progress.
        tick_period = 1;
        do_reset();
        press(8'h3C);
        btn_load = 1'b1;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst reg_a", reg_a, 0);
        check("arst reg_b", reg_b, 0);
        check("arst valid", operands_valid, 0);
        check("arst load_pulse", load_pulse, 0);
        check("arst state", state, 0);
        model_reset();
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (15) step();
        btn_load = 1'b0;
        repeat (15) step();

        // Random stimulus against the model.
        do_reset();
        for (int seg = 0; seg < 150; seg++) begin
            btn_load = ~btn_load;
            tick_period = $urandom_range(1, 3);
            repeat ($urandom_range(1, 20)) begin
                data_in = 8'($urandom);
                clear = ($urandom_range(0, 63) == 0);
                step();
            end
        end
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
